nibble_serial_addsub_ctrl: RTL and testbench

NIBBLE_SERIAL_ADDSUB_CTRL -- requirements
Module: nibble_serial_addsub_ctrl

---
 rtl/nibble_serial_addsub_ctrl_if.sv | 23 ++
 rtl/nibble_serial_addsub_ctrl.sv | 108 ++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Handshake and data bundle for the nibble-serial adder/subtractor.
interface nibble_serial_addsub_ctrl_if;
  logic        start;
  logic        M;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] S;
  logic        Cout;
  logic        V;
  logic        Z;

  modport master (
    output start, M, A, B,
    input  busy, done, S, Cout, V, Z
  );

  modport slave (
    input  start, M, A, B,
    output busy, done, S, Cout, V, Z
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// 16-bit add/subtract computed one nibble per cycle; results are committed
// in one step at the end so S/Cout/V/Z never expose partial sums.
module nibble_serial_addsub_ctrl (
  input  logic                           clk,
  input  logic                           rst,
  nibble_serial_addsub_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [1:0]  idx;
  logic        c;
  logic        m_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] sum_q;
  logic [15:0] s_q;
  logic        cout_q;
  logic        v_q;
  logic        z_q;

  logic [3:0]  a_n;
  logic [3:0]  b_n;
  logic [4:0]  nsum;
  logic [15:0] sum_next;
  logic        v_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (idx == 2'd3) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1; the +1 enters as the initial carry c = M.
  always_comb begin
    a_n      = a_q[{idx, 2'b00} +: 4];
    b_n      = b_q[{idx, 2'b00} +: 4];
    nsum     = {1'b0, a_n} + {1'b0, (m_q ? ~b_n : b_n)} + {4'b0000, c};
    sum_next = sum_q;
    sum_next[{idx, 2'b00} +: 4] = nsum[3:0];
    if (m_q)
      v_next = (~a_q[15] &  b_q[15] &  sum_next[15]) | (a_q[15] & ~b_q[15] & ~sum_next[15]);
    else
      v_next = (~a_q[15] & ~b_q[15] &  sum_next[15]) | (a_q[15] &  b_q[15] & ~sum_next[15]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      c      <= 1'b0;
      m_q    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
      z_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            m_q   <= bus.M;
            sum_q <= '0;
            idx   <= '0;
            c     <= bus.M;
          end
        end
        RUN: begin
          sum_q <= sum_next;
          c     <= nsum[4];
          idx   <= idx + 2'd1;
          if (idx == 2'd3) begin
            s_q    <= sum_next;
            cout_q <= nsum[4];
            z_q    <= (sum_next == 16'h0000);
            v_q    <= v_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for nibble_serial_addsub_ctrl; inputs driven and outputs
// sampled on the falling edge, expected values hand-computed.
module tb_nibble_serial_addsub_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] prev_s = 16'h0000;

  nibble_serial_addsub_ctrl_if bus ();

  nibble_serial_addsub_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge
  // of the idle cycle after DONE so the next call exercises back-to-back start.
  task automatic do_op(input string tag, input logic m, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] es,
                       input logic ec, input logic ev, input logic ez);
    int done_at;
    done_at   = 0;
    bus.start = 1'b1;
    bus.M     = m;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 4) begin
        chk({tag, "_busy"}, bus.busy, 1'b1);
        chk({tag, "_hold"}, bus.S, prev_s);
      end
      if (bus.done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    chk({tag, "_lat"}, done_at, 5);
    chk({tag, "_busy_done"}, bus.busy, 1'b0);
    chk({tag, "_S"}, bus.S, es);
    chk({tag, "_C"}, bus.Cout, ec);
    chk({tag, "_V"}, bus.V, ev);
    chk({tag, "_Z"}, bus.Z, ez);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.done, 1'b0);
    chk({tag, "_idle"}, bus.busy, 1'b0);
    prev_s = es;
  endtask

  initial begin
    int ndone;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.M     = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_S",    bus.S, 16'h0000);
    chk("rst_CVZ",  {bus.Cout, bus.V, bus.Z}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_nostart", bus.busy, 1'b0);

    do_op("add1",  1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);
    do_op("sub1",  1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    do_op("ovfa",  1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op("ovfs",  1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    do_op("subeq", 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op("addw",  1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op("addn",  1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1);

    // Start held through RUN with operands changed mid-operation.
    ndone     = 0;
    bus.start = 1'b1;
    bus.M     = 1'b0;
    bus.A     = 16'h1111;
    bus.B     = 16'h2222;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus.M = 1'b1;
        bus.A = 16'hFFFF;
        bus.B = 16'hFFFF;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        chk("held_S", bus.S, 16'h3333);
        chk("held_CVZ", {bus.Cout, bus.V, bus.Z}, 3'b000);
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("held_ndone", ndone, 1);
    prev_s = 16'h3333;

    do_op("ovfs2", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Reset in the second RUN cycle aborts with no done pulse.
    bus.start = 1'b1;
    bus.M     = 1'b0;
    bus.A     = 16'h1234;
    bus.B     = 16'h0FFF;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_S",    bus.S, 16'h0000);
    chk("abort_CVZ",  {bus.Cout, bus.V, bus.Z}, 3'b000);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    chk("abort_quiet", ndone, 0);
    prev_s = 16'h0000;

    do_op("fresh", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
